// File: rtl/seq_signed_multiplier.sv
// Sequential radix-2 shift-add multiplier for two's complement operands.
// Reports unsigned magnitude plus separate sign and zero flags.
module seq_signed_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   MP,
    input  logic [WIDTH-1:0]   MC,
    output logic [2*WIDTH-1:0] product,
    output logic               sign,
    output logic               zero_flag,
    output logic               done,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   mp_r;
    logic [2*WIDTH-1:0] mc_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [CW-1:0]      cnt;
    logic               raw_sign;
    logic [WIDTH-1:0]   mp_mag;
    logic [WIDTH-1:0]   mc_mag;
    logic               last_step;
    logic               start;

    // Negating the most-negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    assign mp_mag = MP[WIDTH-1] ? (~MP + WIDTH'(1)) : MP;
    assign mc_mag = MC[WIDTH-1] ? (~MC + WIDTH'(1)) : MC;

    assign acc_nx    = acc + (mp_r[0] ? mc_r : '0);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign start     = load && (state != RUN);
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (load) state_nx = RUN;
            RUN:  if (last_step) state_nx = DONE;
            DONE: if (load) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mp_r      <= '0;
            mc_r      <= '0;
            acc       <= '0;
            cnt       <= '0;
            raw_sign  <= 1'b0;
            product   <= '0;
            sign      <= 1'b0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            mp_r     <= mp_mag;
            mc_r     <= {{WIDTH{1'b0}}, mc_mag};
            acc      <= '0;
            cnt      <= '0;
            raw_sign <= MP[WIDTH-1] ^ MC[WIDTH-1];
            done     <= 1'b0;
        end else if (state == RUN) begin
            acc  <= acc_nx;
            mp_r <= mp_r >> 1;
            mc_r <= mc_r << 1;
            cnt  <= cnt + CW'(1);
            // Final step publishes the result; negative zero is suppressed.
            if (last_step) begin
                product   <= acc_nx;
                zero_flag <= (acc_nx == '0);
                sign      <= raw_sign && (acc_nx != '0);
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier.
// Directed vectors; results are checked by a separate monitor.
`timescale 1ns/1ps
module tb_seq_signed_multiplier;

    logic        clk;
    logic        rst;
    logic        load;
    logic [7:0]  MP;
    logic [7:0]  MC;
    logic [15:0] product;
    logic        sign;
    logic        zero_flag;
    logic        done;
    logic        busy;

    typedef struct packed {
        logic [15:0] p;
        logic        s;
        logic        z;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;
    logic done_q = 1'b0;
    logic [15:0] last_prod = 16'd0;

    seq_signed_multiplier #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .MP        (MP),
        .MC        (MC),
        .product   (product),
        .sign      (sign),
        .zero_flag (zero_flag),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compare on each rising edge of done.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("product", {16'd0, product}, {16'd0, e.p});
                chk("sign", {31'd0, sign}, {31'd0, e.s});
                chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
            end
        end
        done_q = done;
    end

    task automatic run_op(input logic [7:0] mp, input logic [7:0] mc,
                          input logic [15:0] ep, input logic es,
                          input logic ez, input int repulse,
                          input int abort_at);
        int   busy_cnt;
        int   lat;
        logic got;
        exp_t e;
        busy_cnt = 0;
        lat = 0;
        got = 1'b0;
        MP = mp;
        MC = mc;
        load = 1'b1;
        if (abort_at < 0) begin
            e.p = ep;
            e.s = es;
            e.z = ez;
            q.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                load = 1'b0;
                MP = 8'hA5;
                MC = 8'h3C;
                chk("done_drop", {31'd0, done}, 32'd0);
            end
            if (k == 1 || k == 8)
                chk("prod_hold", {16'd0, product}, {16'd0, last_prod});
            if (k == repulse + 1) load = 1'b0;
            if (k == repulse) begin
                MP = 8'd9;
                MC = 8'd9;
                load = 1'b1;
            end
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_clear",
                    {12'd0, product, sign, zero_flag, done, busy}, 32'd0);
                last_prod = 16'd0;
                return;
            end
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                lat = k - 1;
                break;
            end
        end
        load = 1'b0;
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", lat, 32'd8);
            chk("busy_cycles", busy_cnt, 32'd8);
            chk("busy_low", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("done_hold", {31'd0, done}, 32'd1);
            chk("result_hold", {16'd0, product}, {16'd0, ep});
            last_prod = ep;
        end
    endtask

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        MP   = 8'd0;
        MC   = 8'd0;
        #1;
        chk("reset_state",
            {12'd0, product, sign, zero_flag, done, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(8'd5,   8'd3,   16'd15,    1'b0, 1'b0, -1, -1);
        run_op(8'hF9,  8'd6,   16'd42,    1'b1, 1'b0, -1, -1);
        run_op(8'h80,  8'h80,  16'd16384, 1'b0, 1'b0, -1, -1);
        run_op(8'd0,   8'hFB,  16'd0,     1'b0, 1'b1, -1, -1);
        run_op(8'd3,   8'd4,   16'd12,    1'b0, 1'b0,  3, -1);
        run_op(8'h7F,  8'h80,  16'd16256, 1'b1, 1'b0, -1, -1);
        run_op(8'hFF,  8'hFF,  16'd1,     1'b0, 1'b0, -1, -1);

        run_op(8'd100, 8'd100, 16'd10000, 1'b0, 1'b0, -1,  4);
        @(negedge clk);
        chk("reset_held",
            {12'd0, product, sign, zero_flag, done, busy}, 32'd0);
        rst = 1'b1;
        run_op(8'd2,   8'd2,   16'd4,     1'b0, 1'b0, -1, -1);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_signed_multiplier.md
SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port load, input, 1: start request, sampled on the rising edge of clk.
REQ-005 SHALL have port MP, input, WIDTH: multiplier, two's complement.
REQ-006 SHALL have port MC, input, WIDTH: multiplicand, two's complement.
REQ-007 SHALL have port product, output, 2*WIDTH: unsigned magnitude of MP*MC, registered.
REQ-008 SHALL have port sign, output, 1: 1 = result negative, registered.
REQ-009 SHALL have port zero_flag, output, 1: 1 = result is zero, registered.
REQ-010 SHALL have port done, output, 1: result valid, level held, registered.
REQ-011 SHALL have port busy, output, 1: high while state is RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, load=1 at an edge SHALL do all of the following: capture |MP| and |MC| as WIDTH-bit unsigned values; capture MP[WIDTH-1]^MC[WIDTH-1] as raw sign; clear the accumulator and the bit counter; go to RUN; deassert done.
REQ-014 Magnitude SHALL be taken in two's complement. The most-negative operand (-128 for WIDTH=8) SHALL yield unsigned 128 without overflow.
REQ-015 RUN SHALL perform one radix-2 shift-add step per cycle. If the multiplier LSB is 1, add the left-shifted multiplicand to a 2*WIDTH-bit accumulator. Then shift the multiplier right and the multiplicand left, and increment the counter.
REQ-016 After exactly WIDTH RUN steps, the FSM SHALL go to DONE. In the same edge it SHALL load product, zero_flag and sign. Latency: load sampled at edge N gives done=1 and a valid product after edge N+WIDTH (N+8 at default).
REQ-017 The result SHALL set zero_flag = (accumulator == 0) and sign = raw sign AND NOT zero_flag. A negative zero is never reported.
REQ-018 product, sign and zero_flag SHALL hold their previous values during RUN and update only on entry to DONE.
REQ-019 In RUN, load SHALL be ignored, and MP/MC changes SHALL have no effect on the operation in progress.
REQ-020 DONE SHALL hold done=1 and the outputs until load=1. Load in DONE restarts per REQ-013, and done falls at that edge.
REQ-021 In IDLE, done SHALL be 0. load=0 SHALL keep the current state in IDLE and DONE.
REQ-022 busy SHALL be 1 exactly during the WIDTH RUN cycles.

Reset
REQ-023 rst=0 SHALL immediately, without waiting for clk, force state IDLE and product=0, sign=0, zero_flag=0, done=0, busy=0. It SHALL also clear the accumulator, the operand registers and the counter.
REQ-024 rst asserted during RUN SHALL abort the operation; no partial result SHALL appear on product.
REQ-025 After rst returns to 1, the block SHALL accept load on the first following clk edge.

Verification
REQ-026 SHALL test MP=5, MC=3, load pulse -> after 8 edges: product=15, sign=0, zero_flag=0, done=1, busy low.
REQ-027 SHALL test MP=0xF9 (-7), MC=6 -> product=42, sign=1, zero_flag=0. Then MP=0x80, MC=0x80 (-128*-128) -> product=16384, sign=0.
REQ-028 SHALL test MP=0, MC=0xFB (-5) -> product=0, zero_flag=1, sign=0.
REQ-029 SHALL test 3*4 started, then load re-pulsed with MP=9, MC=9 at RUN cycle 3 -> result 12, done at original N+8, busy continuous for 8 cycles.
REQ-030 SHALL test rst=0 at RUN cycle 4 of a 100*100 operation -> all outputs 0 immediately. Then a new load with 2*2 -> product=4 after 8 edges.
REQ-031 SHALL test back-to-back operations: a load in DONE -> done drops at that edge, and the old product holds until the new result is loaded.
